// File: rtl/rr_arb_n.sv
// rr_arb_n: N-way round-robin arbiter with hold-until-release grants.
// A requester keeps its grant while its request stays high. With MAX_HOLD > 0,
// an owner that has held for MAX_HOLD cycles while others wait is preempted.
// Every release or preemption is followed by at least one idle grant cycle.
module rr_arb_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 0,
    localparam int IDXW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic            grant_vld,
    output logic [IDXW-1:0] grant_idx,
    output logic            preempt
);

    // Hold counter only needs to reach MAX_HOLD-1; it saturates there.
    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_CAP = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : {HCW{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_r;
    logic [N-1:0]    grant_r;
    logic            grant_vld_r;
    logic [IDXW-1:0] grant_idx_r;
    logic            preempt_r;
    logic [IDXW-1:0] last_r;
    logic [HCW-1:0]  hold_cnt_r;

    logic            win_found_s;
    logic [IDXW-1:0] win_idx_s;
    int              cand_s;
    logic            owner_req_s;
    logic            others_s;
    logic            preempt_hit_s;

    // One-hot vector for a requester index.
    function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [N-1:0] v;
        v = {N{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Rotating-priority search: scan from farthest to nearest after last winner so the nearest set request wins.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IDXW{1'b0}};
        cand_s      = 0;
        for (int k = N; k >= 1; k--) begin
            cand_s = (int'(last_r) + k) % N;
            if (req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDXW'(cand_s);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Owner status and preemption condition while busy.
    always_comb begin
        owner_req_s   = req[grant_idx_r];
        others_s      = |(req & ~grant_r);
        if (MAX_HOLD > 0) begin
            preempt_hit_s = (hold_cnt_r >= HOLD_CAP) && others_s;
        end else begin
            preempt_hit_s = 1'b0;
        end
    end

    // Arbiter FSM with registered grant outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            grant_r     <= {N{1'b0}};
            grant_vld_r <= 1'b0;
            grant_idx_r <= {IDXW{1'b0}};
            preempt_r   <= 1'b0;
            last_r      <= IDXW'(N - 1);
            hold_cnt_r  <= {HCW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    preempt_r  <= 1'b0;
                    hold_cnt_r <= {HCW{1'b0}};
                    if (win_found_s) begin
                        state_r     <= ST_BUSY;
                        grant_r     <= onehot(win_idx_s);
                        grant_vld_r <= 1'b1;
                        grant_idx_r <= win_idx_s;
                        last_r      <= win_idx_s;
                    end else begin
                        state_r     <= ST_IDLE;
                        grant_r     <= {N{1'b0}};
                        grant_vld_r <= 1'b0;
                        grant_idx_r <= {IDXW{1'b0}};
                    end
                end
                ST_BUSY: begin
                    if (!owner_req_s || preempt_hit_s) begin
                        // Release or revoke: competing requests wait for the idle cycle.
                        state_r     <= ST_IDLE;
                        grant_r     <= {N{1'b0}};
                        grant_vld_r <= 1'b0;
                        grant_idx_r <= {IDXW{1'b0}};
                        preempt_r   <= owner_req_s;
                        hold_cnt_r  <= {HCW{1'b0}};
                    end else begin
                        preempt_r <= 1'b0;
                        if (hold_cnt_r != HOLD_CAP) begin
                            hold_cnt_r <= hold_cnt_r + HCW'(1);
                        end else begin
                            hold_cnt_r <= hold_cnt_r;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    grant_r     <= {N{1'b0}};
                    grant_vld_r <= 1'b0;
                    grant_idx_r <= {IDXW{1'b0}};
                    preempt_r   <= 1'b0;
                    hold_cnt_r  <= {HCW{1'b0}};
                end
            endcase
        end
    end

    assign grant     = grant_r;
    assign grant_vld = grant_vld_r;
    assign grant_idx = grant_idx_r;
    assign preempt   = preempt_r;

endmodule
